// File: rtl/slave_memory_initiator_pkg.sv
// Shared widths, command opcodes and FSM encoding for the slave memory initiator.
package slave_memory_initiator_pkg;

  localparam int SMI_DATA_W = 12;
  localparam int SMI_ADDR_W = 5;
  localparam int SMI_DEPTH  = 32;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_BURST = 2'b10,
    OP_RSVD  = 2'b11
  } smi_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_RESP  = 2'b11
  } smi_state_e;

endpackage

// File: rtl/slave_memory_initiator.sv
// Command-driven initiator for a falling-edge-sampled target memory: single writes,
// single reads and wrapping burst reads; every output is a flop, responses held until consumed.
module slave_memory_initiator
  import slave_memory_initiator_pkg::*;
#(
  parameter int DATA_W = SMI_DATA_W,
  parameter int ADDR_W = SMI_ADDR_W,
  parameter int DEPTH  = SMI_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_node,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_node,
  output logic              busy
);

  smi_state_e        state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              mem_write_q, mem_write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              rsp_last_q, rsp_last_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              cmd_acc;

  assign cmd_acc = cmd_valid && cmd_ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_last_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      mem_write_q <= mem_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_last_q  <= rsp_last_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Reserved opcode is accepted but leaves the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          case (smi_op_e'(cmd_op))
            OP_WRITE:          state_d = ST_WRITE;
            OP_READ, OP_BURST: state_d = ST_READ;
            default:           state_d = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ:  state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_d = rsp_last_q ? ST_IDLE : ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_write_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_last_d  = rsp_last_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          case (smi_op_e'(cmd_op))
            OP_WRITE: begin
              mem_write_d = 1'b1;
              wr_addr_d   = cmd_addr;
              wr_data_d   = cmd_data;
            end
            OP_READ: begin
              rd_addr_d = cmd_addr;
              count_d   = '0;
            end
            OP_BURST: begin
              rd_addr_d = cmd_addr;
              count_d   = cmd_len;
            end
            default: ;
          endcase
        end
      end
      // Target has sampled rd_addr on the falling edge, so its data is valid here.
      ST_READ: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_read_node;
        rsp_addr_d  = rd_addr_q;
        rsp_last_d  = (count_q == '0);
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!rsp_last_q) begin
            rd_addr_d = (rd_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr_q + ADDR_W'(1);
            count_d   = count_q - ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_addr       = rsp_addr_q;
  assign rsp_last       = rsp_last_q;
  assign mem_write      = mem_write_q;
  assign mem_write_addr = wr_addr_q;
  assign mem_write_node = wr_data_q;
  assign mem_read_addr  = rd_addr_q;

endmodule

// File: tb/tb_slave_memory_initiator.sv
// Bench for slave_memory_initiator: falling-edge target memory plus a shadow memory model
// that predicts every response from the command stream alone.
module tb_slave_memory_initiator;

  localparam int DW    = 12;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_last;
  logic          mem_write;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_node;
  logic [AW-1:0] mem_read_addr;
  logic [DW-1:0] mem_read_node;
  logic          busy;

  slave_memory_initiator dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_node(mem_write_node),
    .mem_read_addr(mem_read_addr), .mem_read_node(mem_read_node), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] tmem    [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int wr_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Target memory: write first, then present the addressed word, all on the falling edge.
  always @(negedge clk) begin
    if (mem_write) begin
      tmem[mem_write_addr] = mem_write_node;
      wr_cnt++;
    end
    mem_read_node = tmem[mem_read_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [AW-1:0] len, input logic [DW-1:0] d);
    int t = 0;
    while (!cmd_ready && t < 40) begin
      step();
      t++;
    end
    check_eq("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_len   = AW'($urandom);
    cmd_data  = DW'($urandom);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int w0 = wr_cnt;
    send_cmd(2'b00, a, AW'($urandom), d);
    check_eq("wr_strobe", mem_write, 1);
    check_eq("wr_addr", mem_write_addr, a);
    check_eq("wr_data", mem_write_node, d);
    check_eq("wr_busy", busy, 1);
    step();
    check_eq("wr_strobe_off", mem_write, 0);
    check_eq("wr_count", wr_cnt - w0, 1);
    check_eq("wr_hold_addr", mem_write_addr, a);
    check_eq("wr_idle_ready", cmd_ready, 1);
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] len,
                         input int hold_min, input int hold_max);
    int n = (op == 2'b10) ? int'(len) + 1 : 1;
    int w0 = wr_cnt;
    send_cmd(op, a, len, DW'($urandom));
    check_eq("rd_busy", busy, 1);
    check_eq("rd_noready", cmd_ready, 0);
    for (int i = 0; i < n; i++) begin
      int ea = (int'(a) + i) % DEPTH;
      int t = 0;
      int hold;
      logic [DW-1:0] sd;
      logic [AW-1:0] sa, ra;
      logic sl;
      while (!rsp_valid && t < 20) begin
        step();
        t++;
      end
      check_eq("rsp_latency", t, 1);
      check_eq("rsp_data", rsp_data, ref_mem[ea]);
      check_eq("rsp_addr", rsp_addr, ea);
      check_eq("rsp_last", rsp_last, (i == n - 1) ? 1 : 0);
      sd = rsp_data; sa = rsp_addr; sl = rsp_last; ra = mem_read_addr;
      hold = $urandom_range(hold_max, hold_min);
      for (int h = 0; h < hold; h++) begin
        step();
        check_eq("hold_valid", rsp_valid, 1);
        check_eq("hold_data", rsp_data, sd);
        check_eq("hold_addr", rsp_addr, sa);
        check_eq("hold_last", rsp_last, sl);
        check_eq("hold_rdaddr", mem_read_addr, ra);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check_eq("rsp_drop", rsp_valid, 0);
    end
    check_eq("rd_done_busy", busy, 0);
    check_eq("rd_done_ready", cmd_ready, 1);
    step();
    check_eq("rd_no_extra", rsp_valid, 0);
    check_eq("rd_no_write", wr_cnt - w0, 0);
  endtask

  task automatic do_rsvd(input logic [AW-1:0] a);
    int w0 = wr_cnt;
    send_cmd(2'b11, a, AW'($urandom), DW'($urandom));
    check_eq("rsv_busy", busy, 0);
    check_eq("rsv_ready", cmd_ready, 1);
    check_eq("rsv_rsp", rsp_valid, 0);
    step();
    check_eq("rsv_rsp2", rsp_valid, 0);
    check_eq("rsv_nowrite", wr_cnt - w0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tmem[i]    = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_wr_addr", mem_write_addr, 0);
    check_eq("rst_rd_addr", mem_read_addr, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b1;
    step();
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_rsp_last", rsp_last, 0);

    // Write then read back at the same address.
    do_write(5'd7, 12'h5A3);
    do_read(2'b01, 5'd7, 5'd9, 0, 0);

    // Back-to-back write and read of the same word.
    do_write(5'd12, 12'hFFF);
    do_read(2'b01, 5'd12, 5'd0, 0, 0);

    for (int k = 0; k < DEPTH; k++) do_write(AW'(k), DW'(k * 3));
    do_read(2'b10, 5'd30, 5'd3, 0, 0);
    do_read(2'b10, 5'd0, 5'd2, 5, 5);
    do_read(2'b10, 5'd0, 5'd31, 0, 0);

    do_rsvd(5'd4);
    do_read(2'b01, 5'd4, 5'd0, 0, 1);

    // Reset while a 4-word burst response is being held.
    send_cmd(2'b10, 5'd8, 5'd3, 12'h0);
    step();
    check_eq("mid_rsp_valid", rsp_valid, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_rsp_valid", rsp_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_rd_addr", mem_read_addr, 0);
    repeat (2) step();
    reset = 1'b1;
    step();
    check_eq("post_rst_ready", cmd_ready, 1);
    check_eq("post_rst_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      rsp_ready = 1'b1;
      step();
      check_eq("post_rst_norsp", rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    for (int it = 0; it < 60; it++) begin
      int r = $urandom_range(9, 0);
      logic [AW-1:0] a = AW'($urandom);
      if (r <= 3)      do_write(a, DW'($urandom));
      else if (r <= 5) do_read(2'b01, a, AW'($urandom), 0, 3);
      else if (r <= 8) do_read(2'b10, a, AW'($urandom_range(7, 0)), 0, 2);
      else             do_rsvd(a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
